shift_add_multiplier: RTL and testbench

- Sequential unsigned shift-and-add multiplier; inverse-operation companion to the iterative divider in the same arithmetic unit.
- Takes a start pulse plus operands a and b; produces a 2*WIDTH-bit product as hi/lo halves after WIDTH iteration cycles.
- Uses the same start/operand/result handshake style as the divider, so a bench or datapath can drive either block the same way.

---
 rtl/shift_add_multiplier.sv | 76 +++++++
 tb/tb_shift_add_multiplier.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier.
// Loads a/b on start, then retires one multiplier bit per clock. After WIDTH
// iterations it publishes the 2*WIDTH-bit product on hi/lo. hi/lo hold the
// previous product for the whole computation, so they never show a partial value.
module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // The count must reach WIDTH-1 without wrapping.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   mcand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CW-1:0]      count_reg;

    logic [WIDTH:0]     sum_next;
    logic [2*WIDTH-1:0] acc_next;

    // One iteration: add the multiplicand into the upper half when the current
    // multiplier bit is set. Shift the carry into the accumulator so the
    // product stays exact.
    always_comb begin
        sum_next = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                 + (acc_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
        acc_next = {sum_next, acc_reg[WIDTH-1:1]};
    end

    // Control FSM and datapath registers. start takes priority in every state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            mcand_reg <= '0;
            acc_reg   <= '0;
            count_reg <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else if (start) begin
            state_reg <= RUN;
            mcand_reg <= a;
            acc_reg   <= {{WIDTH{1'b0}}, b};
            count_reg <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else if (state_reg == RUN) begin
            acc_reg   <= acc_next;
            count_reg <= count_reg + 1'b1;
            if (count_reg == LAST) begin
                hi        <= acc_next[2*WIDTH-1:WIDTH];
                lo        <= acc_next[WIDTH-1:0];
                busy      <= 1'b0;
                done      <= 1'b1;
                state_reg <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier.
// Covers a WIDTH=32 instance and a WIDTH=8 instance.
module tb_shift_add_multiplier;

    logic        clock = 1'b1;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8;
    logic        done8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    int tests = 0;
    int fails = 0;

    // The clock period is 4. Rising edges fall at t = 4, 8, 12, ...
    always #2 clock = ~clock;

    shift_add_multiplier #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Load the operands over exactly one edge. Then scramble a/b so that any
    // sampling after the load shows up as a wrong product.
    task automatic go(input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        a = x;
        b = y;
        tick();
        start = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Run the remaining 31 iterations and check that nothing is published
    // early. Then take the final edge and check the product.
    task automatic finish_op(input string tag, input logic [31:0] old_hi, input logic [31:0] old_lo,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        run(31);
        check({tag, " done_early"}, {63'd0, done}, 64'd0);
        check({tag, " hi_hold"}, {32'd0, hi}, {32'd0, old_hi});
        check({tag, " lo_hold"}, {32'd0, lo}, {32'd0, old_lo});
        tick();
        check({tag, " done"}, {63'd0, done}, 64'd1);
        check({tag, " busy"}, {63'd0, busy}, 64'd0);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
        $display("[TB] %s: hi=%08h lo=%08h", tag, hi, lo);
    endtask

    initial begin
        // Reset pulse between edges.
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst done", {63'd0, done}, 64'd0);
        check("rst hi", {32'd0, hi}, 64'd0);
        check("rst lo", {32'd0, lo}, 64'd0);

        // Basic case: start over the edge at t=4. The result is visible at t=133.
        go(32'd7, 32'd3);
        check("7x3 busy", {63'd0, busy}, 64'd1);
        finish_op("7x3", 32'd0, 32'd0, 32'd0, 32'd21);
        check("7x3 time", 64'($time), 64'd133);

        // Extreme operands.
        go(32'hFFFFFFFF, 32'hFFFFFFFF);
        finish_op("max*max", 32'd0, 32'd21, 32'hFFFFFFFE, 32'h00000001);
        go(32'd0, 32'h12345678);
        finish_op("0*x", 32'hFFFFFFFE, 32'h00000001, 32'd0, 32'd0);
        go(32'h80000000, 32'd2);
        finish_op("msb*2", 32'd0, 32'd0, 32'd1, 32'd0);

        // Restart: the 10th post-load edge samples start again.
        go(32'd5, 32'd6);
        run(9);
        check("restart done", {63'd0, done}, 64'd0);
        go(32'd9, 32'd9);
        check("restart busy", {63'd0, busy}, 64'd1);
        finish_op("restart 9x9", 32'd1, 32'd0, 32'd0, 32'd81);

        // Held start: there is no progress while start is high.
        start = 1'b1;
        a = 32'd100;
        b = 32'd200;
        run(4);
        check("held busy", {63'd0, busy}, 64'd1);
        check("held done", {63'd0, done}, 64'd0);
        go(32'd100, 32'd200);
        finish_op("held 100x200", 32'd0, 32'd81, 32'd0, 32'd20000);

        // Asynchronous reset mid-run, asserted between edges.
        go(32'd123, 32'd456);
        run(14);
        reset = 1'b1;
        #1;
        check("arst busy", {63'd0, busy}, 64'd0);
        check("arst done", {63'd0, done}, 64'd0);
        check("arst lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;
        go(32'd4, 32'd4);
        finish_op("4x4", 32'd0, 32'd0, 32'd0, 32'd16);

        // Back-to-back operation directly after done.
        go(32'd1000, 32'd1000);
        finish_op("1000x1000", 32'd0, 32'd16, 32'd0, 32'd1000000);

        // WIDTH=8 instance.
        start8 = 1'b1;
        a8 = 8'd255;
        b8 = 8'd255;
        tick();
        start8 = 1'b0;
        a8 = 8'd0;
        b8 = 8'd0;
        run(7);
        check("w8 done_early", {63'd0, done8}, 64'd0);
        tick();
        check("w8 done", {63'd0, done8}, 64'd1);
        check("w8 hi", {56'd0, hi8}, 64'hFE);
        check("w8 lo", {56'd0, lo8}, 64'h01);
        $display("[TB] w8 255x255: hi=%02h lo=%02h", hi8, lo8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
